bcd_glyph_streamer: RTL and testbench

- Sits between the BCD measurement counter and the SSD1306 driver in the frequency-counter display path.
- On a refresh strobe it latches the BCD digits and the decimal-point position, then issues one sync (home cursor) to the driver.
- It then streams exactly one page of 128 glyph column bytes (16 characters x 8 columns) over the driver's strobe/ready handshake.
- It holds ready high only while idle, so the counter reset is released only between frames.

---
 rtl/bcd_glyph_pkg.sv | 23 ++
 rtl/bcd_glyph_streamer_if.sv | 21 ++
 rtl/glyph_rom.sv | 33 +++
 rtl/bcd_glyph_streamer.sv | 155 +++++++++++++++
 tb/tb_bcd_glyph_streamer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_glyph_pkg.sv
// Shared types and constants for the BCD-to-glyph display streamer.
package bcd_glyph_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SYNC     = 3'd1,
        SYNC_GAP = 3'd2,
        SEND     = 3'd3,
        SEND_GAP = 3'd4
    } state_t;

    localparam logic [3:0] CH_DOT   = 4'd10;
    localparam logic [3:0] CH_BLANK = 4'd11;
    localparam logic [3:0] CH_DASH  = 4'd12;

    localparam int unsigned GLYPH_COLS = 8;

    // Out-of-range BCD values are shown as a dash.
    function automatic logic [3:0] glyph_code(input logic [3:0] digit);
        return (digit > 4'd9) ? CH_DASH : digit;
    endfunction

endpackage

// File: rtl/bcd_glyph_streamer_if.sv
// Strobe/ready handshake towards the SSD1306 driver.
interface bcd_glyph_streamer_if;
    logic [7:0] oled_data_out;
    logic       oled_write_stb_out;
    logic       oled_sync_stb_out;
    logic       oled_ready_in;

    modport master (
        output oled_data_out,
        output oled_write_stb_out,
        output oled_sync_stb_out,
        input  oled_ready_in
    );

    modport slave (
        input  oled_data_out,
        input  oled_write_stb_out,
        input  oled_sync_stb_out,
        output oled_ready_in
    );
endinterface

// File: rtl/glyph_rom.sv
// 8x8 font lookup: one column byte per (char code, column), LSB is the top pixel.
module glyph_rom
    import bcd_glyph_pkg::*;
(
    input  logic [3:0] char_code,
    input  logic [2:0] column,
    output logic [7:0] glyph_c
);

    logic [63:0] row;

    // Column 0 sits in the top byte; glyphs are 5 wide with a blank lead-in column.
    always_comb begin
        row = 64'h0;
        case (char_code)
            4'd0:     row = 64'h00_3E_51_49_45_3E_00_00;
            4'd1:     row = 64'h00_00_42_7F_40_00_00_00;
            4'd2:     row = 64'h00_42_61_51_49_46_00_00;
            4'd3:     row = 64'h00_21_41_45_4B_31_00_00;
            4'd4:     row = 64'h00_18_14_12_7F_10_00_00;
            4'd5:     row = 64'h00_27_45_45_45_39_00_00;
            4'd6:     row = 64'h00_3C_4A_49_49_30_00_00;
            4'd7:     row = 64'h00_01_71_09_05_03_00_00;
            4'd8:     row = 64'h00_36_49_49_49_36_00_00;
            4'd9:     row = 64'h00_06_49_49_29_1E_00_00;
            CH_DOT:   row = 64'h00_00_60_60_00_00_00_00;
            CH_DASH:  row = 64'h00_08_08_08_08_08_00_00;
            default:  row = 64'h0;
        endcase
        glyph_c = row[{~column, 3'b000} +: 8];
    end

endmodule

// File: rtl/bcd_glyph_streamer.sv
// Renders latched BCD digits into one page of glyph columns and streams it to the OLED driver.
module bcd_glyph_streamer
    import bcd_glyph_pkg::*;
#(
    parameter int unsigned DIGITS_NUM = 6,
    parameter int unsigned LINE_CHARS = 16
) (
    input  logic                      clk_in,
    input  logic                      resetn_in,
    input  logic [4*DIGITS_NUM-1:0]   digits_in,
    input  logic [2:0]                dec_point_position_in,
    input  logic                      refresh_stb_in,
    output logic                      ready_out,
    bcd_glyph_streamer_if.master      oled
);

    localparam int unsigned DIG_W  = 4 * DIGITS_NUM;
    localparam int unsigned CHAR_W = (LINE_CHARS > 1) ? $clog2(LINE_CHARS) : 1;
    localparam int unsigned COL_W  = $clog2(GLYPH_COLS);

    state_t              state_q, state_d;
    logic [CHAR_W-1:0]   char_q, char_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [DIG_W-1:0]    digits_q, digits_d;
    logic [2:0]          dp_q, dp_d;
    logic                ready_q, ready_d;
    logic [7:0]          data_q, data_d;
    logic                wstb_q, wstb_d;
    logic                sstb_q, sstb_d;
    logic [3:0]          code_c;
    logic [7:0]          glyph_c;

    // Character at line position pos: digits MSB first, optional dot, blank padding.
    function automatic logic [3:0] char_at(input logic [DIG_W-1:0] digs,
                                           input logic [2:0]       dp,
                                           input logic [CHAR_W-1:0] pos);
        int         p;
        int         c;
        int         i;
        logic       has_dot;
        logic       above_nz;
        logic [3:0] d;
        logic [3:0] code;
        p       = int'(dp);
        has_dot = (p >= 1) && (p < int'(DIGITS_NUM));
        if (!has_dot) p = 0;
        c        = int'(pos);
        i        = -1;
        d        = 4'd0;
        above_nz = 1'b0;
        code     = CH_BLANK;
        if (has_dot && (c == int'(DIGITS_NUM) - p)) code = CH_DOT;
        else if (c < int'(DIGITS_NUM) - p)          i = int'(DIGITS_NUM) - 1 - c;
        else if (has_dot && (c <= int'(DIGITS_NUM))) i = int'(DIGITS_NUM) - c;
        if (i >= 0) begin
            for (int j = 0; j < int'(DIGITS_NUM); j++) begin
                if (j == i) d = digs[4*j +: 4];
                if ((j > i) && (digs[4*j +: 4] != 4'd0)) above_nz = 1'b1;
            end
            // The digit left of the point (or digit 0) and everything right of it stay visible.
            if ((d == 4'd0) && !above_nz && (i > p)) code = CH_BLANK;
            else                                      code = glyph_code(d);
        end
        return code;
    endfunction

    assign code_c = char_at(digits_q, dp_q, char_q);

    glyph_rom u_glyph_rom (
        .char_code (code_c),
        .column    (col_q),
        .glyph_c   (glyph_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        char_d   = char_q;
        col_d    = col_q;
        digits_d = digits_q;
        dp_d     = dp_q;
        data_d   = data_q;
        wstb_d   = 1'b0;
        sstb_d   = 1'b0;
        ready_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (refresh_stb_in) begin
                    digits_d = digits_in;
                    dp_d     = dec_point_position_in;
                    char_d   = '0;
                    col_d    = '0;
                    state_d  = SYNC;
                end
            end
            SYNC: begin
                if (oled.oled_ready_in) begin
                    sstb_d  = 1'b1;
                    state_d = SYNC_GAP;
                end
            end
            SYNC_GAP: state_d = SEND;
            SEND: begin
                if (oled.oled_ready_in) begin
                    wstb_d  = 1'b1;
                    data_d  = glyph_c;
                    col_d   = col_q + COL_W'(1);
                    state_d = SEND_GAP;
                    if (col_q == COL_W'(GLYPH_COLS - 1)) begin
                        char_d = char_q + CHAR_W'(1);
                        if (char_q == CHAR_W'(LINE_CHARS - 1)) begin
                            char_d  = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            SEND_GAP: state_d = SEND;
            default:  state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            state_q  <= IDLE;
            char_q   <= '0;
            col_q    <= '0;
            digits_q <= '0;
            dp_q     <= '0;
            ready_q  <= 1'b1;
            data_q   <= 8'h00;
            wstb_q   <= 1'b0;
            sstb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            char_q   <= char_d;
            col_q    <= col_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            ready_q  <= ready_d;
            data_q   <= data_d;
            wstb_q   <= wstb_d;
            sstb_q   <= sstb_d;
        end
    end

    assign ready_out               = ready_q;
    assign oled.oled_data_out      = data_q;
    assign oled.oled_write_stb_out = wstb_q;
    assign oled.oled_sync_stb_out  = sstb_q;

endmodule

// File: tb/tb_bcd_glyph_streamer.sv
// Frame-level scoreboard bench for bcd_glyph_streamer: expected sync/byte stream per frame.
module tb_bcd_glyph_streamer;

    typedef struct packed {
        logic [23:0]  digits;
        logic [2:0]   dp;
        logic [127:0] chars;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] digits;
    logic [2:0]  dp;
    logic        refresh;
    logic        ready;
    int          ready_mode;

    int n_vec = 0;
    int n_bad = 0;
    int sb[$];
    int wr_count = 0;
    int sync_count = 0;
    int cycle = 0;
    int last_stb = -10;

    vec_t tbl[7];

    bcd_glyph_streamer_if oled_if ();

    bcd_glyph_streamer #(.DIGITS_NUM(6), .LINE_CHARS(16)) dut (
        .clk_in                (clk),
        .resetn_in             (rst_n),
        .digits_in             (digits),
        .dec_point_position_in (dp),
        .refresh_stb_in        (refresh),
        .ready_out             (ready),
        .oled                  (oled_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Driver-side ready: 0 = always ready, 1 = random back-pressure, 2 = stalled.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       oled_if.oled_ready_in = ($urandom_range(0, 3) != 0);
            2:       oled_if.oled_ready_in = 1'b0;
            default: oled_if.oled_ready_in = 1'b1;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [63:0] font(input logic [7:0] ch);
        case (ch)
            "0":     return 64'h00_3E_51_49_45_3E_00_00;
            "1":     return 64'h00_00_42_7F_40_00_00_00;
            "2":     return 64'h00_42_61_51_49_46_00_00;
            "3":     return 64'h00_21_41_45_4B_31_00_00;
            "4":     return 64'h00_18_14_12_7F_10_00_00;
            "5":     return 64'h00_27_45_45_45_39_00_00;
            "6":     return 64'h00_3C_4A_49_49_30_00_00;
            "7":     return 64'h00_01_71_09_05_03_00_00;
            "8":     return 64'h00_36_49_49_49_36_00_00;
            "9":     return 64'h00_06_49_49_29_1E_00_00;
            ".":     return 64'h00_00_60_60_00_00_00_00;
            "-":     return 64'h00_08_08_08_08_08_00_00;
            default: return 64'h0;
        endcase
    endfunction

    // Sync token (-1) followed by 128 column bytes.
    task automatic push_frame(input logic [127:0] s);
        logic [7:0]  ch;
        logic [63:0] row;
        sb.push_back(-1);
        for (int c = 0; c < 16; c++) begin
            ch  = s[127 - 8*c -: 8];
            row = font(ch);
            for (int k = 0; k < 8; k++) sb.push_back(int'(row[63 - 8*k -: 8]));
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        int exp;
        if (rst_n && (oled_if.oled_sync_stb_out || oled_if.oled_write_stb_out)) begin
            check("strobe_gap", int'(last_stb == cycle - 1), 0);
            check("dual_strobe", int'(oled_if.oled_sync_stb_out && oled_if.oled_write_stb_out), 0);
            last_stb = cycle;
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_strobe: got sync=%0b write=%0b required none", oled_if.oled_sync_stb_out, oled_if.oled_write_stb_out);
            end else begin
                exp = sb.pop_front();
                if (oled_if.oled_sync_stb_out) begin
                    check("sync_position", -1, exp);
                    sync_count++;
                    wr_count = 0;
                end else begin
                    check("write_byte", int'(oled_if.oled_data_out), exp);
                    wr_count++;
                end
            end
        end
    end

    task automatic pulse_refresh(input logic [23:0] d, input logic [2:0] p);
        @(posedge clk);
        #2;
        digits  = d;
        dp      = p;
        refresh = 1'b1;
        @(posedge clk);
        #2;
        refresh = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            #1;
            if (ready && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: got ready=%0b pending=%0d required idle", name, ready, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_writes(input int n);
        bit ok = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            #1;
            if (wr_count >= n) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL write_wait_timeout: got %0d writes required %0d", wr_count, n);
        end
    endtask

    task automatic end_of_frame_checks();
        check("frame_writes", wr_count, 128);
        check("frame_syncs", sync_count, 1);
        check("ready_idle", int'(ready), 1);
    endtask

    task automatic run_frame(input logic [23:0] d, input logic [2:0] p, input logic [127:0] s);
        push_frame(s);
        wr_count   = 0;
        sync_count = 0;
        pulse_refresh(d, p);
        check("ready_busy", int'(ready), 0);
        wait_idle("frame");
        end_of_frame_checks();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_bad;
        tbl[0] = '{24'h012345, 3'd5, "0.12345         "};
        tbl[1] = '{24'h000042, 3'd0, "    42          "};
        tbl[2] = '{24'h000000, 3'd3, "  0.000         "};
        tbl[3] = '{24'h00A001, 3'd0, "  -001          "};
        tbl[4] = '{24'h123456, 3'd7, "123456          "};
        tbl[5] = '{24'h100000, 3'd1, "10000.0         "};
        tbl[6] = '{24'h0000F0, 3'd2, "   0.-0         "};

        rst_n      = 1'b0;
        refresh    = 1'b0;
        digits     = '0;
        dp         = '0;
        ready_mode = 0;
        oled_if.oled_ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", int'(ready), 1);
        check("reset_data", int'(oled_if.oled_data_out), 0);
        check("reset_write_stb", int'(oled_if.oled_write_stb_out), 0);
        check("reset_sync_stb", int'(oled_if.oled_sync_stb_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            ready_mode = (i >= 4) ? 1 : 0;
            run_frame(tbl[i].digits, tbl[i].dp, tbl[i].chars);
        end
        ready_mode = 0;

        // Driver stalled for 100 cycles right after the refresh.
        ready_mode = 2;
        repeat (2) @(posedge clk);
        push_frame("98.7654         ");
        wr_count   = 0;
        sync_count = 0;
        pulse_refresh(24'h987654, 3'd4);
        stall_bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (oled_if.oled_sync_stb_out || oled_if.oled_write_stb_out || ready) stall_bad++;
        end
        check("stall_quiet", stall_bad, 0);
        ready_mode = 0;
        wait_idle("stall_resume");
        end_of_frame_checks();

        // Refresh and digit change in the middle of a frame are ignored.
        push_frame("   123          ");
        wr_count   = 0;
        sync_count = 0;
        pulse_refresh(24'h000123, 3'd0);
        wait_writes(40);
        pulse_refresh(24'h999999, 3'd0);
        check("midframe_busy", int'(ready), 0);
        wait_idle("midframe");
        end_of_frame_checks();
        run_frame(24'h999999, 3'd0, "999999          ");

        // Asynchronous reset part way through a frame.
        push_frame(" 543.21         ");
        wr_count   = 0;
        sync_count = 0;
        pulse_refresh(24'h054321, 3'd2);
        wait_writes(70);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", int'(ready), 1);
        check("async_rst_data", int'(oled_if.oled_data_out), 0);
        check("async_rst_write_stb", int'(oled_if.oled_write_stb_out), 0);
        check("async_rst_sync_stb", int'(oled_if.oled_sync_stb_out), 0);
        sb.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_idle", int'(ready), 1);
        run_frame(24'h000007, 3'd0, "     7          ");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
